// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. Looked up by the fetch PC
// with one cycle of latency, and trained by resolved-branch feedback.
// After reset, a sweep clears one valid bit per cycle before predictions are enabled.
module branch_predictor #(
  parameter int AWIDTH  = 32,
  parameter int ENTRIES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [AWIDTH-1:0] fetch_pc,
  output logic              pred_valid,
  output logic [AWIDTH-1:0] pred_pc,
  output logic              pred_taken,
  output logic [AWIDTH-1:0] pred_target,
  input  logic              fb_taken,
  input  logic              fb_not_taken,
  input  logic [AWIDTH-1:0] fb_pc,
  input  logic [AWIDTH-1:0] fb_target,
  output logic              ready
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = AWIDTH - IDX_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_init_idx;
  logic               r_ready;

  // Only the valid bits need clearing; tag/target/ctr are qualified by valid.
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [AWIDTH-1:0]  r_tgt [ENTRIES];
  logic [1:0]         r_ctr [ENTRIES];

  logic [IDX_W-1:0]   w_lk_idx, w_fb_idx;
  logic [TAG_W-1:0]   w_lk_tag, w_fb_tag;
  logic               w_lk_hit, w_fb_hit, w_lk_taken;
  logic [1:0]         w_fb_ctr;

  assign w_lk_idx   = fetch_pc[IDX_W-1:0];
  assign w_lk_tag   = fetch_pc[AWIDTH-1:IDX_W];
  assign w_fb_idx   = fb_pc[IDX_W-1:0];
  assign w_fb_tag   = fb_pc[AWIDTH-1:IDX_W];
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_fb_hit   = r_valid[w_fb_idx] && (r_tag[w_fb_idx] == w_fb_tag);
  assign w_fb_ctr   = r_ctr[w_fb_idx];
  // Gating with ready keeps pred_taken low during the sweep, when table contents are stale.
  assign w_lk_taken = r_ready && w_lk_hit && r_ctr[w_lk_idx][1];

  // Init/run control: sweep index and the ready flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_idx <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_idx <= r_init_idx + 1'b1;
          if (r_init_idx == IDX_W'(ENTRIES - 1)) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        default: r_ready <= 1'b1;
      endcase
    end
  end

  // Table writes: sweep clear in INIT, feedback training in RUN (fb_taken has priority)
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_INIT) begin
        r_valid[r_init_idx] <= 1'b0;
      end else if (fb_taken) begin
        r_tgt[w_fb_idx] <= fb_target;
        if (w_fb_hit) begin
          if (w_fb_ctr != 2'd3) r_ctr[w_fb_idx] <= w_fb_ctr + 2'd1;
        end else begin
          r_valid[w_fb_idx] <= 1'b1;
          r_tag[w_fb_idx]   <= w_fb_tag;
          r_ctr[w_fb_idx]   <= 2'd2;
        end
      end else if (fb_not_taken && w_fb_hit) begin
        // A not-taken result at ctr 0 evicts the entry so that an aliasing PC can claim the slot.
        if (w_fb_ctr != 2'd0) r_ctr[w_fb_idx]   <= w_fb_ctr - 2'd1;
        else                  r_valid[w_fb_idx] <= 1'b0;
      end
    end
  end

  // Registered prediction outputs; the lookup sees contents from before this cycle's update
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid  <= 1'b0;
      pred_pc     <= '0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid  <= fetch_valid;
      pred_pc     <= fetch_pc;
      pred_taken  <= w_lk_taken;
      pred_target <= w_lk_taken ? r_tgt[w_lk_idx] : fetch_pc + AWIDTH'(1);
    end
  end

  assign ready = r_ready;
endmodule
